// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the elapsed_timer slice.
//   timer_state_t  - FSM state encoding (IDLE, RUN, PAUSE, EXPIRED)
//   DIGIT_W        - width of one BCD digit
//   *_MAX          - roll-over value of each digit position
//   bcd_inc        - value a digit takes on the next edge given its enable
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } timer_state_t;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] SEC_UNITS_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX  = 4'd5;
    localparam logic [DIGIT_W-1:0] MIN_UNITS_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] MIN_TENS_MAX  = 4'd9;

    // Post-increment value of one digit; lets the top level see the count
    // the digits are about to load without waiting for the edge.
    function automatic logic [DIGIT_W-1:0] bcd_inc(
        input logic [DIGIT_W-1:0] q,
        input logic [DIGIT_W-1:0] max,
        input logic               en
    );
        logic [DIGIT_W-1:0] r;
        r = q;
        if (en) begin
            r = (q == max) ? '0 : q + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_up_digit.sv
// bcd_up_digit: one decade (or modulo MAX+1) BCD up-counter digit.
// Ports:
//   clock     - rising-edge clock
//   reset     - asynchronous active-low reset, q -> 0
//   enable    - count up by one this cycle (carry-in from the lower digit)
//   clear     - synchronous q -> 0 (highest priority after reset)
//   load_max  - synchronous q -> MAX (used to hold a saturated count)
//   q         - current digit value, 0..MAX
//   carry     - enable & (q == MAX): the digit rolls over on this edge
module bcd_up_digit
    import timer_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = 4'd9
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear,
    input  logic               load_max,
    output logic [DIGIT_W-1:0] q,
    output logic               carry
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load_max) begin
            q <= MAX;
        end else if (enable) begin
            q <= (q == MAX) ? '0 : q + 4'd1;
        end
    end

    // Combinational carry so all four digits ripple within one cycle.
    assign carry = enable & (q == MAX);

endmodule

// File: rtl/elapsed_timer.sv
// elapsed_timer: mm:ss BCD up-counter (00:00..99:59) with start/stop/clear
// control and a programmable target that ends a watering period.
// Ports:
//   clock, reset           - rising-edge clock, async active-low reset
//   tick                   - one-cycle count enable (nominally 1 Hz)
//   start, stop, clear     - control; priority clear > stop > start
//   target_min, target_sec - BCD target; 00:00 or any invalid digit = no limit
//   elapsed_min/sec        - BCD count
//   running                - state is RUN
//   done                   - one-cycle pulse when the count reaches target
//   expired                - state is EXPIRED
//   overflow               - one-cycle pulse on a tick at 99:59 in RUN
//   state_dbg              - registered FSM state, for observation
// Parameter SATURATE: 1 holds 99:59 on overflow, 0 wraps to 00:00.
module elapsed_timer
    import timer_pkg::*;
#(
    parameter bit SATURATE = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         tick,
    input  logic         start,
    input  logic         stop,
    input  logic         clear,
    input  logic [7:0]   target_min,
    input  logic [7:0]   target_sec,
    output logic [7:0]   elapsed_min,
    output logic [7:0]   elapsed_sec,
    output logic         running,
    output logic         done,
    output logic         expired,
    output logic         overflow,
    output timer_state_t state_dbg
);

    timer_state_t state_q, state_d;

    logic [DIGIT_W-1:0] su_q, st_q, mu_q, mt_q;
    logic               su_c, st_c, mu_c, mt_c;
    logic               inc, full, sat_hold, cnt_en;
    logic [DIGIT_W-1:0] su_n, st_n, mu_n, mt_n;
    logic               target_ok, match;
    logic               done_q, overflow_q;

    // A tick only counts in RUN; stop or clear in the same cycle wins.
    assign inc      = (state_q == ST_RUN) && tick && !stop && !clear;
    assign full     = (su_q == SEC_UNITS_MAX) && (st_q == SEC_TENS_MAX) &&
                      (mu_q == MIN_UNITS_MAX) && (mt_q == MIN_TENS_MAX);
    assign sat_hold = inc && full && SATURATE;
    assign cnt_en   = inc && !sat_hold;

    bcd_up_digit #(.MAX(SEC_UNITS_MAX)) u_sec_units (
        .clock(clock), .reset(reset), .enable(cnt_en), .clear(clear),
        .load_max(sat_hold), .q(su_q), .carry(su_c)
    );
    bcd_up_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clock(clock), .reset(reset), .enable(su_c), .clear(clear),
        .load_max(sat_hold), .q(st_q), .carry(st_c)
    );
    bcd_up_digit #(.MAX(MIN_UNITS_MAX)) u_min_units (
        .clock(clock), .reset(reset), .enable(st_c), .clear(clear),
        .load_max(sat_hold), .q(mu_q), .carry(mu_c)
    );
    bcd_up_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clock(clock), .reset(reset), .enable(mu_c), .clear(clear),
        .load_max(sat_hold), .q(mt_q), .carry(mt_c)
    );

    // Value the digits will hold after this edge; the target is compared
    // against it so done lines up with the tick that reaches the target.
    assign su_n = bcd_inc(su_q, SEC_UNITS_MAX, cnt_en);
    assign st_n = bcd_inc(st_q, SEC_TENS_MAX,  su_c);
    assign mu_n = bcd_inc(mu_q, MIN_UNITS_MAX, st_c);
    assign mt_n = bcd_inc(mt_q, MIN_TENS_MAX,  mu_c);

    // 00:00 means "no limit"; malformed BCD can never be reached.
    assign target_ok = (target_min[7:4] <= MIN_TENS_MAX)  &&
                       (target_min[3:0] <= MIN_UNITS_MAX) &&
                       (target_sec[7:4] <= SEC_TENS_MAX)  &&
                       (target_sec[3:0] <= SEC_UNITS_MAX) &&
                       ({target_min, target_sec} != 16'h0000);

    // Only a real increment can match, so a target lowered below the
    // current count (or a held saturated count) never fires.
    assign match = cnt_en && target_ok &&
                   ({mt_n, mu_n, st_n, su_n} == {target_min, target_sec});

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_PAUSE: begin
                    if (!stop && start) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (stop)       state_d = ST_PAUSE;
                    else if (match) state_d = ST_EXPIRED;
                end
                ST_EXPIRED: state_d = ST_EXPIRED;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= match;
            // Wrap shows up as a carry out of the top digit; saturation
            // suppresses the carry, so it is flagged separately.
            overflow_q <= inc && (mt_c || sat_hold);
        end
    end

    assign elapsed_min = {mt_q, mu_q};
    assign elapsed_sec = {st_q, su_q};
    assign running     = (state_q == ST_RUN);
    assign expired     = (state_q == ST_EXPIRED);
    assign done        = done_q;
    assign overflow    = overflow_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_elapsed_timer.sv
// tb_elapsed_timer: drives a saturating and a wrapping elapsed_timer with the
// same stimulus and checks both against a seconds-count reference model.
module tb_elapsed_timer;
    import timer_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic [7:0] target_min = 8'h00, target_sec = 8'h00;

    logic [7:0]   s_min, s_sec, w_min, w_sec;
    logic         s_running, s_done, s_expired, s_overflow;
    logic         w_running, w_done, w_expired, w_overflow;
    timer_state_t s_state, w_state;

    int n_checks = 0;
    int n_errors = 0;

    elapsed_timer #(.SATURATE(1'b1)) dut_sat (
        .clock(clock), .reset(reset), .tick(tick), .start(start), .stop(stop),
        .clear(clear), .target_min(target_min), .target_sec(target_sec),
        .elapsed_min(s_min), .elapsed_sec(s_sec), .running(s_running),
        .done(s_done), .expired(s_expired), .overflow(s_overflow),
        .state_dbg(s_state)
    );

    elapsed_timer #(.SATURATE(1'b0)) dut_wrap (
        .clock(clock), .reset(reset), .tick(tick), .start(start), .stop(stop),
        .clear(clear), .target_min(target_min), .target_sec(target_sec),
        .elapsed_min(w_min), .elapsed_sec(w_sec), .running(w_running),
        .done(w_done), .expired(w_expired), .overflow(w_overflow),
        .state_dbg(w_state)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // Index 0 models the saturating instance, index 1 the wrapping one.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
    int m_st[2];
    int m_cnt[2];   // elapsed time in whole seconds, 0..5999
    bit m_done[2];
    bit m_ovf[2];

    function automatic logic [15:0] to_bcd(input int c);
        int m, s;
        m = c / 60;
        s = c % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic bit tgt_valid();
        bit ok;
        ok = (target_min[7:4] <= 9) && (target_min[3:0] <= 9) &&
             (target_sec[7:4] <= 5) && (target_sec[3:0] <= 9);
        return ok && ({target_min, target_sec} != 16'h0000);
    endfunction

    function automatic int tgt_secs();
        return (target_min[7:4] * 10 + target_min[3:0]) * 60 +
               target_sec[7:4] * 10 + target_sec[3:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = M_IDLE; m_cnt[i] = 0; m_done[i] = 0; m_ovf[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 0;
            m_ovf[i]  = 0;
            if (clear) begin
                m_st[i] = M_IDLE;
                m_cnt[i] = 0;
            end else if (m_st[i] == M_IDLE || m_st[i] == M_PAUSE) begin
                if (!stop && start) m_st[i] = M_RUN;
            end else if (m_st[i] == M_RUN) begin
                if (stop) begin
                    m_st[i] = M_PAUSE;
                end else if (tick) begin
                    if (m_cnt[i] == 5999) begin
                        m_ovf[i] = 1;
                        if (i == 1) m_cnt[i] = 0;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                        if (tgt_valid() && m_cnt[i] == tgt_secs()) begin
                            m_st[i] = M_EXP;
                            m_done[i] = 1;
                        end
                    end
                end
            end
        end
    endtask

    function automatic timer_state_t m_state_enum(input int i);
        case (m_st[i])
            M_RUN:   return ST_RUN;
            M_PAUSE: return ST_PAUSE;
            M_EXP:   return ST_EXPIRED;
            default: return ST_IDLE;
        endcase
    endfunction

    function automatic logic [31:0] exp_vec(input int i);
        return {10'd0, to_bcd(m_cnt[i]), m_st[i] == M_RUN, m_done[i],
                m_st[i] == M_EXP, m_ovf[i], m_state_enum(i)};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("sat_outputs",
              {10'd0, s_min, s_sec, s_running, s_done, s_expired, s_overflow, s_state},
              exp_vec(0));
        check("wrap_outputs",
              {10'd0, w_min, w_sec, w_running, w_done, w_expired, w_overflow, w_state},
              exp_vec(1));
    endtask

    // ---------------- driver ----------------
    // Inputs change 1 time unit after a rising edge; outputs are sampled there.
    task automatic cycle();
        @(posedge clock);
        if (!reset) model_reset();
        else        model_step();
        #1;
        compare_all();
    endtask

    task automatic run_ticks(input int n);
        tick = 1'b1;
        repeat (n) cycle();
        tick = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; cycle(); clear = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] b;
        model_reset();

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        compare_all();
        check("reset_count", {16'd0, s_min, s_sec}, 32'h0000);
        reset = 1'b1;

        // Target 00:05: five ticks expire, sixth is ignored
        target_min = 8'h00; target_sec = 8'h05;
        pulse_start();
        run_ticks(4);
        tick = 1'b1;
        cycle();
        check("t5_count", {16'd0, s_min, s_sec}, 32'h0005);
        check("t5_done", {31'd0, s_done}, 32'd1);
        check("t5_expired_running", {30'd0, s_expired, s_running}, 32'b10);
        cycle();
        tick = 1'b0;
        check("t6_no_change", {16'd0, w_min, w_sec}, 32'h0005);
        check("t6_done_low", {31'd0, w_done}, 32'd0);
        start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
        check("expired_ignores_ctl", {31'd0, s_expired}, 32'd1);

        // Stop in the same cycle as a tick at 00:10
        target_sec = 8'h00;
        pulse_clear();
        pulse_start();
        run_ticks(10);
        tick = 1'b1; stop = 1'b1;
        cycle();
        tick = 1'b0; stop = 1'b0;
        check("stop_tick_count", {16'd0, s_min, s_sec}, 32'h0010);
        check("stop_tick_state", {30'd0, s_state}, {30'd0, ST_PAUSE});
        pulse_start();
        run_ticks(1);
        check("resume_count", {16'd0, s_min, s_sec}, 32'h0011);

        // Carries 00:59 -> 01:00 and 09:59 -> 10:00
        run_ticks(48);
        check("at_0059", {16'd0, s_min, s_sec}, 32'h0059);
        run_ticks(1);
        check("carry_0100", {16'd0, s_min, s_sec}, 32'h0100);
        run_ticks(539);
        check("at_0959", {16'd0, s_min, s_sec}, 32'h0959);
        run_ticks(1);
        check("carry_1000", {16'd0, w_min, w_sec}, 32'h1000);

        // Full count with target 00:00
        run_ticks(5399);
        check("at_9959", {16'd0, s_min, s_sec, w_min, w_sec} & 32'hFFFF_FFFF, 32'h9959_9959);
        run_ticks(1);
        check("sat_hold", {15'd0, s_min, s_sec, s_overflow}, {15'd0, 16'h9959, 1'b1});
        check("wrap_zero", {15'd0, w_min, w_sec, w_overflow}, {15'd0, 16'h0000, 1'b1});
        run_ticks(1);
        check("sat_still_run", {30'd0, s_running, s_overflow}, 32'b11);
        check("wrap_0001", {15'd0, w_min, w_sec, w_overflow}, {15'd0, 16'h0001, 1'b0});

        // Invalid target 00:6A never matches
        pulse_clear();
        target_min = 8'h00; target_sec = 8'h6A;
        pulse_start();
        run_ticks(120);
        check("invalid_tgt", {14'd0, s_min, s_sec, s_expired, w_expired}, {14'd0, 16'h0200, 2'b00});

        // Asynchronous reset mid-run at 03:27
        target_sec = 8'h00;
        pulse_clear();
        pulse_start();
        run_ticks(207);
        check("at_0327", {16'd0, s_min, s_sec}, 32'h0327);
        tick = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("async_reset", {14'd0, s_min, s_sec, s_running, s_state},
              {14'd0, 16'h0000, 1'b0, ST_IDLE});
        cycle();
        tick = 1'b0;
        reset = 1'b1;
        cycle();

        // clear, start and stop together
        pulse_start();
        run_ticks(3);
        clear = 1'b1; start = 1'b1; stop = 1'b1;
        cycle();
        clear = 1'b0; start = 1'b0; stop = 1'b0;
        check("clr_start_stop", {14'd0, s_min, s_sec, s_state}, {14'd0, 16'h0000, ST_IDLE});

        // Randomized control traffic and targets
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 4) == 0) begin
                    target_min = 8'($urandom_range(0, 255));
                    target_sec = 8'($urandom_range(0, 255));
                end else begin
                    b = to_bcd($urandom_range(0, 90));
                    target_min = b[15:8];
                    target_sec = b[7:0];
                end
            end
            tick  = ($urandom_range(0, 2) != 0);
            start = ($urandom_range(0, 5) == 0);
            stop  = ($urandom_range(0, 11) == 0);
            clear = ($urandom_range(0, 59) == 0);
            cycle();
        end
        tick = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/elapsed_timer.md
# elapsed_timer

- Four-digit BCD up-counter (mm:ss, 00:00 to 99:59) that accumulates irrigation run time from a 1 Hz enable pulse.
- Runs under start/stop/clear control and signals when the elapsed time reaches a programmed target.
- Counterpart to the timer's decade down-counters: counts up instead of down and propagates a carry instead of a borrow.
- Drives the display path and tells the irrigation controller that a watering period has completed.

## Interface
- SATURATE, default 1: 1 = hold at 99:59 when the count is full; 0 = wrap to 00:00.
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low. Clears all state and outputs.
- tick  input  1  one-cycle enable pulse, nominally 1 Hz.
- start  input  1  begin or resume counting.
- stop  input  1  pause counting.
- clear  input  1  synchronous return to IDLE with count 00:00.
- target_min  input  8  BCD minutes target, [7:4] tens, [3:0] units.
- target_sec  input  8  BCD seconds target, tens 0–5.
- elapsed_min  output  8  BCD elapsed minutes.
- elapsed_sec  output  8  BCD elapsed seconds.
- running  output  1  high in RUN.
- done  output  1  one-cycle pulse when elapsed first equals target.
- expired  output  1  level, high in EXPIRED.
- overflow  output  1  one-cycle pulse on a 99:59 tick while in RUN.

## Operation
- States: IDLE, RUN, PAUSE, EXPIRED.
- Reset values: state IDLE; elapsed 00:00; running, done, expired and overflow all 0.
- Control priority each cycle: clear > stop > start.
  - clear, any state → IDLE, count 00:00, expired 0.
  - IDLE or PAUSE, start → RUN. Count is kept, not cleared.
  - RUN, stop → PAUSE. A tick in the same cycle is ignored.
  - EXPIRED: start and stop are ignored. Only clear or reset leaves this state.
- Count rules:
  - A tick in RUN (and not stop/clear) increments seconds units 0→9.
  - Units carry into seconds tens 0→5.
  - Seconds tens carry into minutes units 0→9, which carry into minutes tens 0→9.
  - Carries ripple combinationally in the same cycle. All four digits update on one edge.
  - Ticks outside RUN are ignored.
- Target match:
  - Evaluated on the post-increment value.
  - If it equals the target and the target is not 00:00: go to EXPIRED, pulse done.
  - Target 00:00 means no limit.
  - A target with any digit above 9, or seconds tens above 5, never matches. Counting continues.
- Target changed mid-run: only future increments are compared. A target already passed does not fire.
- Full count (99:59 plus a tick in RUN):
  - Always pulse overflow for one cycle.
  - SATURATE=1: hold 99:59 and stay in RUN.
  - SATURATE=0: count becomes 00:00.
  - A target of 00:00 never matches after wrap, because 00:00 means no limit.
- Count is always valid BCD. No state produces a digit above 9, or seconds tens above 5.

## Timing
- Latency from a tick sampled at edge N: elapsed, done and overflow all change at edge N (registered outputs).
- done is high for exactly one cycle and is never re-asserted until after clear.
- running and expired follow the registered state with no extra delay.
- start, stop and clear take effect at the next rising edge.
- Reset deasserting mid-operation: the block resumes from IDLE at 00:00.
- Reset asserting: outputs clear immediately, without waiting for a clock edge.

## Structure
- Package timer_pkg holds:
  - the state enum;
  - BCD digit width (4);
  - digit limits SEC_UNITS_MAX=9, SEC_TENS_MAX=5, MIN_UNITS_MAX=9, MIN_TENS_MAX=9.
- Sub-module bcd_up_digit, one per digit, four instances chained:
  - parameter MAX;
  - inputs clock, reset, enable, clear, load_max;
  - outputs q[3:0] and carry, where carry = enable & (q==MAX).
  - The top level holds the FSM and the target comparator.

## Test plan
- Target 00:05, start, 5 ticks → elapsed 00:05, done pulses at the 5th tick edge, expired=1, running=0; 6th tick gives no change.
- Count from 00:59 with one tick → 01:00. From 09:59 → 10:00.
- Stop asserted in the same cycle as a tick at 00:10 → stays 00:10 in PAUSE. Start, then 1 tick → 00:11.
- At 99:59 with target 00:00:
  - SATURATE=1: tick → 99:59 and overflow pulses.
  - SATURATE=0: tick → 00:00 and overflow pulses.
- Target 00:6A (invalid seconds units) → never expires across 120 ticks.
- Reset low mid-run at 03:27 → outputs 00:00 immediately, state IDLE. clear, start and stop all in one cycle → IDLE, 00:00.
